// File: rtl/watch_ctrl_if.sv
// rtl/watch_ctrl_if.sv - button, counter-digit and control signals of the stopwatch controller
// Purpose: bundles everything between the buttons/seconds counter and watch_ctrl.
// Ports (slave view = watch_ctrl):
//   strtstop_i, laprst_i   raw push-button levels
//   lsbsec_i, msbsec_i     live seconds-counter digits (BCD)
//   cntce_o, cntclr_o      count enable / synchronous clear to the seconds counter
//   running_o, laphold_o   status: RUN or LAP / LAP only
//   displsb_o, dispmsb_o   registered display digits
interface watch_ctrl_if;
  logic       strtstop_i;
  logic       laprst_i;
  logic [3:0] lsbsec_i;
  logic [3:0] msbsec_i;
  logic       cntce_o;
  logic       cntclr_o;
  logic       running_o;
  logic       laphold_o;
  logic [3:0] displsb_o;
  logic [3:0] dispmsb_o;

  modport master (
    output strtstop_i, laprst_i, lsbsec_i, msbsec_i,
    input  cntce_o, cntclr_o, running_o, laphold_o, displsb_o, dispmsb_o
  );

  modport slave (
    input  strtstop_i, laprst_i, lsbsec_i, msbsec_i,
    output cntce_o, cntclr_o, running_o, laphold_o, displsb_o, dispmsb_o
  );
endinterface

// File: rtl/watch_ctrl.sv
// rtl/watch_ctrl.sv - run/lap/reset controller for the stopwatch seconds counter
// Purpose: turns the start/stop and lap/reset buttons into count-enable and clear
// strobes, prescales clk_i down to the count rate and freezes the display in LAP.
// Ports:
//   clk_i   system clock, rising edge
//   rst_i   asynchronous active-high reset
//   bus     watch_ctrl_if.slave (buttons, counter digits, strobes, status, display)
// Parameter: TICKDIV clock cycles per count step (>= 2).
module watch_ctrl #(
  parameter int unsigned TICKDIV = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  watch_ctrl_if.slave  bus
);

  localparam int unsigned     PW = $clog2(TICKDIV);
  localparam logic [PW-1:0]   TC = PW'(TICKDIV - 1);

  typedef enum logic [2:0] {
    S_CLEAR,
    S_ZERO,
    S_RUN,
    S_LAP,
    S_STOP
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    ss_sync_q, lr_sync_q;   // [0],[1] synchronizer, [2] edge-detect delay
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    displsb_q, dispmsb_q;
  logic          ss_press, lr_press;
  logic          run_st;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ss_sync_q <= '0;
      lr_sync_q <= '0;
    end else begin
      ss_sync_q <= {ss_sync_q[1:0], bus.strtstop_i};
      lr_sync_q <= {lr_sync_q[1:0], bus.laprst_i};
    end
  end

  // Rising edge of the synchronized level: one pulse per press however long it is held.
  assign ss_press = ss_sync_q[1] & ~ss_sync_q[2];
  assign lr_press = lr_sync_q[1] & ~lr_sync_q[2];

  assign run_st = (state_q == S_RUN) || (state_q == S_LAP);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_CLEAR;
      presc_q   <= '0;
      displsb_q <= '0;
      dispmsb_q <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      // Loading on the last pre-LAP cycle is what captures the lap value.
      if (state_q != S_LAP) begin
        displsb_q <= bus.lsbsec_i;
        dispmsb_q <= bus.msbsec_i;
      end
    end
  end

  // Next state; start/stop is tested first so it wins over a same-cycle lap/reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CLEAR: state_d = S_ZERO;
      S_ZERO:  if (ss_press) state_d = S_RUN;
      S_RUN: begin
        if (ss_press)      state_d = S_STOP;
        else if (lr_press) state_d = S_LAP;
      end
      S_LAP: begin
        if (ss_press)      state_d = S_STOP;
        else if (lr_press) state_d = S_RUN;
      end
      S_STOP: begin
        if (ss_press)      state_d = S_RUN;
        else if (lr_press) state_d = S_CLEAR;
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // Prescaler holds outside RUN/LAP so a resumed run keeps its fractional count.
  always_comb begin
    presc_d = presc_q;
    if (state_q == S_CLEAR) begin
      presc_d = '0;
    end else if (run_st) begin
      presc_d = (presc_q == TC) ? '0 : presc_q + 1'b1;
    end
  end

  assign bus.cntce_o   = run_st && (presc_q == TC);
  assign bus.cntclr_o  = (state_q == S_CLEAR);
  assign bus.running_o = run_st;
  assign bus.laphold_o = (state_q == S_LAP);
  assign bus.displsb_o = displsb_q;
  assign bus.dispmsb_o = dispmsb_q;

endmodule

// File: tb/tb_watch_ctrl.sv
// tb/tb_watch_ctrl.sv - scoreboard bench for watch_ctrl with a seconds-counter environment
module tb_watch_ctrl;
  localparam int TD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  watch_ctrl_if bus();

  watch_ctrl #(.TICKDIV(TD)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Environment: 00..59 BCD seconds counter driven by the DUT strobes.
  logic [3:0] cnt_l = 4'd0;
  logic [3:0] cnt_m = 4'd0;
  always @(posedge clk) begin
    if (bus.cntclr_o) begin
      cnt_l <= 4'd0;
      cnt_m <= 4'd0;
    end else if (bus.cntce_o) begin
      if (cnt_l == 4'd9) begin
        cnt_l <= 4'd0;
        cnt_m <= (cnt_m == 4'd5) ? 4'd0 : cnt_m + 4'd1;
      end else begin
        cnt_l <= cnt_l + 4'd1;
      end
    end
  end
  assign bus.lsbsec_i = cnt_l;
  assign bus.msbsec_i = cnt_m;

  // Reference model: a press seen on the raw pin at edge k takes effect at edge k+2;
  // the count strobe fires on every TD-th cycle spent running since the last clear.
  typedef enum int {M_CLEAR, M_ZERO, M_RUN, M_LAP, M_STOP} mode_t;
  typedef struct packed {
    logic       ce;
    logic       clr;
    logic       run;
    logic       lap;
    logic [3:0] dl;
    logic [3:0] dm;
  } exp_t;

  exp_t  exq[$];
  mode_t mode = M_CLEAR;
  mode_t nm;
  int    runc = 0;
  bit    ss_prev, lr_prev, ss_d1, ss_d2, lr_d1, lr_d2, a_ss, a_lr;
  logic [3:0] m_dl = 4'd0;
  logic [3:0] m_dm = 4'd0;
  exp_t  e_new;

  always @(posedge clk) begin
    if (rst) begin
      mode = M_CLEAR; runc = 0; m_dl = 4'd0; m_dm = 4'd0;
      ss_prev = 0; lr_prev = 0; ss_d1 = 0; ss_d2 = 0; lr_d1 = 0; lr_d2 = 0;
    end else begin
      a_ss = ss_d2; a_lr = lr_d2;
      ss_d2 = ss_d1; lr_d2 = lr_d1;
      ss_d1 = bus.strtstop_i && !ss_prev;
      lr_d1 = bus.laprst_i && !lr_prev;
      ss_prev = bus.strtstop_i;
      lr_prev = bus.laprst_i;
      if (mode != M_LAP) begin m_dl = cnt_l; m_dm = cnt_m; end
      if (mode == M_CLEAR) runc = 0;
      else if (mode == M_RUN || mode == M_LAP) runc++;
      nm = mode;
      case (mode)
        M_CLEAR: nm = M_ZERO;
        M_ZERO:  if (a_ss) nm = M_RUN;
        M_RUN:   if (a_ss) nm = M_STOP; else if (a_lr) nm = M_LAP;
        M_LAP:   if (a_ss) nm = M_STOP; else if (a_lr) nm = M_RUN;
        M_STOP:  if (a_ss) nm = M_RUN;  else if (a_lr) nm = M_CLEAR;
        default: nm = M_CLEAR;
      endcase
      mode = nm;
    end
    e_new.run = (mode == M_RUN) || (mode == M_LAP);
    e_new.lap = (mode == M_LAP);
    e_new.clr = (mode == M_CLEAR);
    e_new.ce  = e_new.run && (((runc + 1) % TD) == 0);
    e_new.dl  = m_dl;
    e_new.dm  = m_dm;
    exq.push_back(e_new);
  end

  int n_chk  = 0;
  int n_fail = 0;
  exp_t e_mon, a_mon;

  always @(negedge clk) begin
    if (exq.size() > 0) begin
      e_mon = exq.pop_front();
      a_mon = {bus.cntce_o, bus.cntclr_o, bus.running_o, bus.laphold_o, bus.displsb_o, bus.dispmsb_o};
      n_chk++;
      if (a_mon !== e_mon) begin
        n_fail++;
        $display("FAIL outputs t=%0t got ce=%b clr=%b run=%b lap=%b disp=%h%h required ce=%b clr=%b run=%b lap=%b disp=%h%h",
                 $time, a_mon.ce, a_mon.clr, a_mon.run, a_mon.lap, a_mon.dm, a_mon.dl,
                 e_mon.ce, e_mon.clr, e_mon.run, e_mon.lap, e_mon.dm, e_mon.dl);
      end
    end
  end

  task automatic check(input string nm_s, input logic [31:0] got, input logic [31:0] req);
    n_chk++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s got %0h required %0h", nm_s, got, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic press(input bit ss, input bit lr);
    bus.strtstop_i = ss;
    bus.laprst_i   = lr;
    cyc(1);
    bus.strtstop_i = 1'b0;
    bus.laprst_i   = 1'b0;
  endtask

  int   ce_cnt;
  int   clr_cnt;
  logic [7:0] snap;

  initial begin
    bus.strtstop_i = 1'b0;
    bus.laprst_i   = 1'b0;
    rst = 1'b1;
    cyc(3);
    rst = 1'b0;
    cyc(6);
    check("idle_disp", {bus.dispmsb_o, bus.displsb_o}, 8'h00);
    check("idle_running", bus.running_o, 1'b0);

    // Run rate and press latency.
    bus.strtstop_i = 1'b1;
    cyc(2);
    check("latency_not_yet", bus.running_o, 1'b0);
    cyc(1);
    check("latency_run", bus.running_o, 1'b1);
    bus.strtstop_i = 1'b0;
    ce_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      ce_cnt += int'(bus.cntce_o);
      cyc(1);
    end
    check("run_ce_pulses", ce_cnt, 10);
    cyc(1);
    check("run_disp_10", {bus.dispmsb_o, bus.displsb_o}, 8'h10);

    // Stop with the last running cycle at prescale 2, then resume.
    cyc(3);
    press(1'b1, 1'b0);
    cyc(2);
    check("stop_running", bus.running_o, 1'b0);
    cyc(20);
    press(1'b1, 1'b0);
    cyc(2);
    check("resume_first_ce", bus.cntce_o, 1'b1);

    // Clear path.
    press(1'b1, 1'b0);
    cyc(2);
    press(1'b0, 1'b1);
    clr_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      clr_cnt += int'(bus.cntclr_o);
      cyc(1);
    end
    check("clear_pulse_count", clr_cnt, 1);
    check("clear_disp", {bus.dispmsb_o, bus.displsb_o}, 8'h00);
    press(1'b0, 1'b1);
    cyc(4);
    check("zero_ignores_lap_run", bus.running_o, 1'b0);
    check("zero_ignores_lap_hold", bus.laphold_o, 1'b0);

    // Lap with the counter at 07.
    press(1'b1, 1'b0);
    cyc(2);
    cyc(27);
    press(1'b0, 1'b1);
    cyc(2);
    check("lap_enter", bus.laphold_o, 1'b1);
    check("lap_frozen_07", {bus.dispmsb_o, bus.displsb_o}, 8'h07);
    ce_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      ce_cnt += int'(bus.cntce_o);
      cyc(1);
    end
    check("lap_ce_continues", ce_cnt, 3);
    check("lap_still_07", {bus.dispmsb_o, bus.displsb_o}, 8'h07);
    check("lap_counter_moved", {cnt_m, cnt_l}, 8'h10);
    press(1'b0, 1'b1);
    cyc(2);
    check("lap_release", {bus.running_o, bus.laphold_o}, 2'b10);
    snap = {cnt_m, cnt_l};
    cyc(1);
    check("disp_lag", {bus.dispmsb_o, bus.displsb_o}, snap);

    // Simultaneous presses in RUN: start/stop wins.
    press(1'b1, 1'b1);
    cyc(2);
    check("simul_stop", {bus.running_o, bus.laphold_o}, 2'b00);
    // Held button: exactly one transition.
    bus.strtstop_i = 1'b1;
    cyc(50);
    bus.strtstop_i = 1'b0;
    cyc(3);
    check("held_one_transition", bus.running_o, 1'b1);

    // Reset mid-run.
    cyc(5);
    rst = 1'b1;
    #1;
    check("reset_clr", {bus.cntclr_o, bus.cntce_o, bus.running_o, bus.laphold_o}, 4'b1000);
    cyc(3);
    rst = 1'b0;
    cyc(5);
    check("post_reset", {bus.running_o, bus.dispmsb_o, bus.displsb_o}, 9'h000);

    // Random buttons with occasional reset.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 11) == 0) bus.strtstop_i = ~bus.strtstop_i;
      if ($urandom_range(0, 11) == 0) bus.laprst_i   = ~bus.laprst_i;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cyc(1);
    end
    rst = 1'b0;
    bus.strtstop_i = 1'b0;
    bus.laprst_i   = 1'b0;
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
